// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment driver. A loaded binary value is converted to BCD by
// a serial double-dabble FSM while the scanner keeps showing the last committed value.
module seven_seg_scanner #(
  parameter int NUM_DIGITS     = 2,
  parameter int VALUE_WIDTH    = 7,
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int BLANK_LEADING  = 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Load,
  input  logic [VALUE_WIDTH-1:0] i_Value,
  output logic [6:0]             o_Segment,
  output logic [NUM_DIGITS-1:0]  o_Digit_En,
  output logic                   o_Busy,
  output logic                   o_Overflow
);

  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Decimal digits needed for 2^VALUE_WIDTH-1 is ceil(VALUE_WIDTH*log10(2)).
  localparam int VAL_DIGITS = (VALUE_WIDTH * 30103 + 99999) / 100000;
  localparam int BCD_DIGITS = (VAL_DIGITS > NUM_DIGITS) ? VAL_DIGITS : NUM_DIGITS;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int DISP_W     = 4 * NUM_DIGITS;
  localparam int BIT_W      = (VALUE_WIDTH > 1) ? $clog2(VALUE_WIDTH) : 1;
  localparam int CNT_W      = $clog2(CLKS_PER_DIGIT);
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned LIMIT = pow10(NUM_DIGITS);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                 state;
  logic [VALUE_WIDTH-1:0] value_reg;
  logic [BCD_W-1:0]       bcd_reg;
  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W-1:0]       bcd_next;
  logic [BIT_W-1:0]       bit_cnt;
  logic                   ovf_cap;
  logic                   busy_reg;
  logic [DISP_W-1:0]      disp_bcd;
  logic                   disp_ovf;

  logic [CNT_W-1:0]       scan_cnt;
  logic [IDX_W-1:0]       digit_idx;
  logic [6:0]             seg_reg;
  logic [NUM_DIGITS-1:0]  en_reg;
  logic [NUM_DIGITS-1:0]  lead_zero;
  logic [NUM_DIGITS-1:0]  blank;
  logic [3:0]             cur_nibble;
  logic [6:0]             seg_next;

  genvar gi;
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign bcd_next = (bcd_adj << 1) | BCD_W'(value_reg[VALUE_WIDTH-1]);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state     <= IDLE;
      value_reg <= '0;
      bcd_reg   <= '0;
      bit_cnt   <= '0;
      ovf_cap   <= 1'b0;
      busy_reg  <= 1'b0;
      disp_bcd  <= '0;
      disp_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_Load) begin
            value_reg <= i_Value;
            bcd_reg   <= '0;
            bit_cnt   <= '0;
            ovf_cap   <= (32'(i_Value) >= LIMIT);
            busy_reg  <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_reg   <= bcd_next;
          value_reg <= value_reg << 1;
          bit_cnt   <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_W'(VALUE_WIDTH - 1)) state <= COMMIT;
        end
        COMMIT: begin
          disp_bcd <= bcd_reg[DISP_W-1:0];
          disp_ovf <= ovf_cap;
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A digit is a leading zero when it and every higher displayed digit are zero.
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign lead_zero[gi] = (disp_bcd[4*gi +: 4] == 4'd0);
      end else begin : g_low
        assign lead_zero[gi] = (disp_bcd[4*gi +: 4] == 4'd0) && lead_zero[gi+1];
      end
      assign blank[gi] = (BLANK_LEADING != 0) && (gi != 0) && lead_zero[gi];
    end
  endgenerate

  assign cur_nibble = disp_bcd[{digit_idx, 2'b00} +: 4];

  always_comb begin
    seg_next = glyph(cur_nibble);
    if (disp_ovf)              seg_next = SEG_DASH;
    else if (blank[digit_idx]) seg_next = SEG_BLANK;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      seg_reg   <= SEG_BLANK;
      en_reg    <= '1;
    end else begin
      seg_reg <= seg_next;
      en_reg  <= ~(NUM_DIGITS'(1) << digit_idx);
      if (scan_cnt == CNT_W'(CLKS_PER_DIGIT - 1)) begin
        scan_cnt  <= '0;
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  assign o_Segment  = seg_reg;
  assign o_Digit_En = en_reg;
  assign o_Busy     = busy_reg;
  assign o_Overflow = disp_ovf;

endmodule
